sram_sp_sync: RTL and testbench
===============================

Name: sram_sp_sync

Overview:
- Synchronous single-port RAM: one address bus shared by read and write, one write enable.
- Default geometry is 1024 x 16. The hash-table tag RAM (sram_w16_d1k) is this block with DATA_WIDTH=16. The MAC/portmap data RAM (sram_w64_d1k) is this block with DATA_WIDTH=64. Both wrappers keep the same port names.
- Used by the 2-way MAC hash bucket. Its client waits up to 2 clocks after driving an address before sampling read data.

Parameters:
- DATA_WIDTH, 16, width of dina/douta in bits (wrapper values 16 and 64).
- ADDR_WIDTH, 10, width of addra.
- DEPTH, 1024, number of words; must be <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, clocks from address sample to douta valid; legal values 1 or 2.

Ports:
- clka  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wea  input  1  write enable for the current cycle.
- addra  input  ADDR_WIDTH  word address for both read and write.
- dina  input  DATA_WIDTH  write data.
- douta  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset
  - While rst is high, douta and any internal pipeline register are 0, asynchronously.
  - Memory array contents are NOT cleared by rst.
  - wea is ignored while rst is high: no write occurs.
  - Reset mid-access: the access is lost. The first valid douta follows READ_LATENCY clocks after rst deasserts and an address is sampled.
- Power-up: the array initialises to all zeros (initial block, simulation and FPGA init).
- Every rising edge with rst low
  - addra is sampled.
  - If wea=1 and addra < DEPTH, mem[addra] <= dina.
- Read path, WRITE_FIRST mode
  - The stage-1 read register loads dina when wea=1.
  - Otherwise it loads mem[addra].
- Latency
  - READ_LATENCY=1: douta = stage-1 register. Data for an address sampled at edge N is visible after edge N.
  - READ_LATENCY=2: an extra output register. Data appears after edge N+1.
- Back-to-back
  - A new address every cycle gives full-throughput reads; one result per clock, in order.
  - A consecutive write then read of the same address returns the newly written data.
- Out of range (addra >= DEPTH)
  - Writes are dropped.
  - Reads return 0.
  - No wrap-around or aliasing.
- Width: data is stored and returned bit-exact. No parity and no byte enables.
- Unknown inputs: if wea is X/Z, treat it as no write; the simulation model issues a warning.
- No internal state machine beyond the optional output pipeline register.
- Client usage that must work
  - Sequential clear: 1024 consecutive cycles of wea=1 with addra incrementing 0..1023 and dina=0 zero every word.
  - Read-modify-write: the client reads, then writes the same address 3 clocks later.

Test Plan:
- Reset: hold rst=1 with wea=1, addra=5, dina=16'hFFFF. Release, then read addr 5 -> douta=0 during reset; readback is the prior content (0 after power-up), proving no write happened.
- Write/read, READ_LATENCY=1, DATA_WIDTH=16: write 16'h8096 to addr 3FF, then wea=0 with addra=3FF -> douta=16'h8096 one clock after the address edge.
- Write-first: at addr 10 write 16'h1234 then 16'h5678 on consecutive cycles -> douta shows 16'h1234 then 16'h5678 on the cycles following each write.
- Streaming read: fill addr 0..1023 with value = address, then read 0..1023 on consecutive cycles -> douta sequence 0,1,...,1023 with no gaps; repeat with READ_LATENCY=2 and check a one-clock extra delay.
- Clear sweep, DATA_WIDTH=64: preload random data, run 1024-cycle wea=1 dina=0 sweep -> every subsequent read returns 64'h0.
- Out of range: DEPTH=1000, write 16'hABCD to addr 1010 -> read addr 1010 returns 0 and addr 1010-1024=-14 (no aliasing: addr 986 unchanged).

Source files
------------

// File: rtl/sram_sp_sync.sv
// Synchronous single-port RAM with a write-first read path and an optional
// second output register (READ_LATENCY 1 or 2). Out-of-range addresses are inert.
module sram_sp_sync #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic                  in_range;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1_d, rd1_q;

    // Declaration initialiser gives the all-zero power-up image; rst never clears it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    assign in_range = ({1'b0, addra} < DEPTH_W);
    // An X/Z wea compares false here, so it never writes.
    assign wr_en    = !rst && (wea == 1'b1) && in_range;

    always_ff @(posedge clka) begin
        if (wr_en)
            mem_q[addra] <= dina;
    end

    always_comb begin
        rd1_d = '0;
        if (in_range)
            rd1_d = (wea == 1'b1) ? dina : mem_q[addra];
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) rd1_q <= '0;
        else     rd1_q <= rd1_d;
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd2_q;
            always_ff @(posedge clka or posedge rst) begin
                if (rst) rd2_q <= '0;
                else     rd2_q <= rd1_q;
            end
            assign douta = rd2_q;
        end else begin : g_lat1
            assign douta = rd1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_sp_sync.sv
// Directed bench: four sram_sp_sync instances (16b/L1, 16b/L2, 64b/L1, 16b/DEPTH=1000).
// u1, u2 and u4 share one stimulus bus; u3 has its own 64-bit bus.
module tb_sram_sp_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] din;
    logic        we3;
    logic [9:0]  addr3;
    logic [63:0] din3;
    logic [15:0] d1, d2, d4;
    logic [63:0] d3;
    logic [63:0] rnd [1024];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sram_sp_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(1)) u1 (
        .clka(clk), .rst(rst), .wea(we), .addra(addr), .dina(din), .douta(d1));
    sram_sp_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(2)) u2 (
        .clka(clk), .rst(rst), .wea(we), .addra(addr), .dina(din), .douta(d2));
    sram_sp_sync #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(1)) u3 (
        .clka(clk), .rst(rst), .wea(we3), .addra(addr3), .dina(din3), .douta(d3));
    sram_sp_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1)) u4 (
        .clka(clk), .rst(rst), .wea(we), .addra(addr), .dina(din), .douta(d4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with a write attempt on every instance
        rst = 1'b1; we = 1'b1; addr = 10'd5; din = 16'hFFFF;
        we3 = 1'b1; addr3 = 10'd5; din3 = '1;
        tick(); tick(); tick();
        chk16("rst_u1", d1, 16'h0);
        chk16("rst_u2", d2, 16'h0);
        chk64("rst_u3", d3, 64'h0);
        chk16("rst_u4", d4, 16'h0);

        rst = 1'b0; we = 1'b0; we3 = 1'b0;
        tick();
        chk16("nowr_u1", d1, 16'h0);
        chk64("nowr_u3", d3, 64'h0);
        tick();
        chk16("nowr_u2", d2, 16'h0);

        // Top-address write then read
        we = 1'b1; addr = 10'h3FF; din = 16'h8096;
        tick();
        we = 1'b0;
        tick();
        chk16("rd3ff_u1", d1, 16'h8096);
        tick();
        chk16("rd3ff_u2", d2, 16'h8096);

        // Write-first on consecutive writes to the same address
        we = 1'b1; addr = 10'd10; din = 16'h1234;
        tick();
        chk16("wf1_u1", d1, 16'h1234);
        din = 16'h5678;
        tick();
        chk16("wf2_u1", d1, 16'h5678);
        chk16("wf2_u2", d2, 16'h1234);
        we = 1'b0;
        tick();
        chk16("wf3_u2", d2, 16'h5678);

        // Fill value = address (u1/u2/u4), random preload on u3
        for (int i = 0; i < 1024; i++) begin
            we = 1'b1; addr = 10'(i); din = 16'(i);
            rnd[i] = {$urandom(), $urandom()};
            we3 = 1'b1; addr3 = 10'(i); din3 = rnd[i];
            tick();
        end
        we = 1'b0; we3 = 1'b0;

        // Streaming read, one address per clock
        for (int i = 0; i <= 1024; i++) begin
            if (i < 1024) begin
                addr = 10'(i); addr3 = 10'(i);
            end
            tick();
            if (i < 1024) begin
                chk16("strm_u1", d1, 16'(i));
                chk64("strm_u3", d3, rnd[i]);
                chk16("strm_u4", d4, (i < 1000) ? 16'(i) : 16'h0);
            end
            if (i > 0)
                chk16("strm_u2", d2, 16'(i - 1));
        end

        // 64-bit clear sweep then full readback
        for (int i = 0; i < 1024; i++) begin
            we3 = 1'b1; addr3 = 10'(i); din3 = 64'h0;
            tick();
        end
        we3 = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            addr3 = 10'(i);
            tick();
            chk64("clr_u3", d3, 64'h0);
        end

        // Out of range on DEPTH=1000 instance
        we = 1'b1; addr = 10'd1010; din = 16'hABCD;
        tick();
        we = 1'b0;
        tick();
        chk16("oor_u4", d4, 16'h0);
        chk16("inr_u1", d1, 16'hABCD);
        addr = 10'd986;
        tick();
        chk16("noalias986_u4", d4, 16'd986);
        addr = 10'd10;
        tick();
        chk16("noalias10_u4", d4, 16'd10);

        // Asynchronous clear of the output registers, array retained
        addr = 10'd986;
        tick();
        rst = 1'b1;
        #1;
        chk16("arst_u1", d1, 16'h0);
        chk16("arst_u2", d2, 16'h0);
        tick();
        rst = 1'b0;
        tick();
        chk16("post_rst_u1", d1, 16'd986);
        chk16("post_rst_u2_pipe", d2, 16'h0);
        tick();
        chk16("post_rst_u2", d2, 16'd986);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
